// File: rtl/br_predict_unit_pkg.sv
// Shared definitions for the branch unit: branch codes, BTB entry kinds,
// 2-bit counter states and the counter update helper.
package br_predict_unit_pkg;

    // Branch codes carried by res_cb
    localparam logic [3:0] CB_NONE = 4'd0;
    localparam logic [3:0] CB_J    = 4'd1;
    localparam logic [3:0] CB_JAL  = 4'd2;
    localparam logic [3:0] CB_JR   = 4'd3;
    localparam logic [3:0] CB_BEQ  = 4'd4;
    localparam logic [3:0] CB_BNE  = 4'd5;
    localparam logic [3:0] CB_BLEZ = 4'd6;
    localparam logic [3:0] CB_BGTZ = 4'd7;
    localparam logic [3:0] CB_BLTZ = 4'd8;
    localparam logic [3:0] CB_BGEZ = 4'd9;

    // What a BTB entry describes
    typedef enum logic [1:0] {
        KIND_COND   = 2'd0,
        KIND_UNCOND = 2'd1,
        KIND_RET    = 2'd2
    } btb_kind_t;

    // 2-bit saturating counter states
    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    // Saturating counter step toward the resolved direction
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        if (taken) n = (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
        else       n = (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/br_predict_unit_ras.sv
// Return-address stack: circular buffer, oldest entry overwritten when full,
// pop on empty is ignored.
module br_ras #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [31:0]                push_data,
    output logic [31:0]                top,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

    logic [31:0]   stack [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_ptr;

    // ptr names the next free slot, so the top sits one below it
    always_comb begin
        top_ptr = ptr - ONE;
        top     = stack[top_ptr];
    end

    // Push/pop bookkeeping with saturating count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else if (push) begin
            stack[ptr] <= push_data;
            ptr        <= ptr + ONE;
            if (count != FULL) count <= count + 1'b1;
        end else if (pop && count != '0) begin
            ptr   <= top_ptr;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/br_predict_unit.sv
// Branch unit: fetch-side BTB/counter/RAS predictor and execute-side resolver
// producing a registered one-cycle redirect on mispredict.
module br_predict_unit
    import br_predict_unit_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned RAS_DEPTH   = 4,
    parameter logic [1:0]  CTR_INIT    = 2'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic [3:0]  res_cb,
    input  logic [31:0] res_rs,
    input  logic [31:0] res_rt,
    input  logic [15:0] res_offset,
    input  logic [25:0] res_index,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_tgt,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] ra
);
    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = 30 - IDX;
    localparam int unsigned RCW  = $clog2(RAS_DEPTH) + 1;

    logic            btb_valid [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag   [BTB_ENTRIES];
    btb_kind_t       btb_kind  [BTB_ENTRIES];
    logic [31:0]     btb_tgt   [BTB_ENTRIES];
    logic [1:0]      btb_ctr   [BTB_ENTRIES];

    logic [31:0]    ras_top;
    logic [RCW-1:0] ras_count;

    logic [IDX-1:0]  f_idx, r_idx;
    logic [TAGW-1:0] f_tag, r_tag;
    logic            f_hit, r_hit_cond;

    logic        active, is_cond, taken, mispredict;
    logic [31:0] btgt, jtgt, fall, act_tgt;

    // Fetch lookup; reads current table contents, so a same-cycle update is not visible
    always_comb begin
        f_idx       = fetch_pc[IDX+1:2];
        f_tag       = fetch_pc[31:IDX+2];
        f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
        pred_taken  = 1'b0;
        pred_target = fetch_pc + 32'd8;
        if (f_hit) begin
            case (btb_kind[f_idx])
                KIND_COND: if (btb_ctr[f_idx][1]) begin
                    pred_taken  = 1'b1;
                    pred_target = btb_tgt[f_idx];
                end
                KIND_UNCOND: begin
                    pred_taken  = 1'b1;
                    pred_target = btb_tgt[f_idx];
                end
                KIND_RET: if (ras_count != '0) begin
                    pred_taken  = 1'b1;
                    pred_target = ras_top;
                end
                default: ;
            endcase
        end
    end

    // Resolve: outcome, correct target and mispredict detection
    always_comb begin
        btgt    = res_pc + 32'd4 + {{14{res_offset[15]}}, res_offset, 2'b00};
        jtgt    = {res_pc[31:28], res_index, 2'b00};
        fall    = res_pc + 32'd8;
        active  = res_valid && (res_cb != CB_NONE);
        is_cond = 1'b0;
        taken   = 1'b0;
        act_tgt = fall;
        case (res_cb)
            CB_BEQ:  begin is_cond = 1'b1; taken = (res_rs == res_rt); end
            CB_BNE:  begin is_cond = 1'b1; taken = (res_rs != res_rt); end
            CB_BLEZ: begin is_cond = 1'b1; taken = ($signed(res_rs) <= 0); end
            CB_BGTZ: begin is_cond = 1'b1; taken = ($signed(res_rs) > 0); end
            CB_BLTZ: begin is_cond = 1'b1; taken = ($signed(res_rs) < 0); end
            CB_BGEZ: begin is_cond = 1'b1; taken = ($signed(res_rs) >= 0); end
            CB_J, CB_JAL: begin taken = 1'b1; act_tgt = jtgt; end
            CB_JR:   begin taken = 1'b1; act_tgt = res_rs; end
            default: ;
        endcase
        if (is_cond && taken) act_tgt = btgt;
        mispredict = (taken != res_pred_taken) || (taken && (act_tgt != res_pred_tgt));
        ra         = (res_cb == CB_JAL) ? fall : '0;
        r_idx      = res_pc[IDX+1:2];
        r_tag      = res_pc[31:IDX+2];
        r_hit_cond = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag) && (btb_kind[r_idx] == KIND_COND);
    end

    // Registered redirect; dropped immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= active && mispredict;
            if (active) redirect_pc <= act_tgt;
        end
    end

    // BTB and counter training from the resolved branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_tag[i]   <= '0;
                btb_kind[i]  <= KIND_COND;
                btb_tgt[i]   <= '0;
                btb_ctr[i]   <= CTR_INIT;
            end
        end else if (active) begin
            if (is_cond) begin
                if (r_hit_cond) begin
                    btb_ctr[r_idx] <= ctr_next(btb_ctr[r_idx], taken);
                end else if (taken) begin
                    btb_valid[r_idx] <= 1'b1;
                    btb_tag[r_idx]   <= r_tag;
                    btb_kind[r_idx]  <= KIND_COND;
                    btb_tgt[r_idx]   <= btgt;
                    btb_ctr[r_idx]   <= CTR_WT;
                end
            end else if (res_cb == CB_J || res_cb == CB_JAL) begin
                btb_valid[r_idx] <= 1'b1;
                btb_tag[r_idx]   <= r_tag;
                btb_kind[r_idx]  <= KIND_UNCOND;
                btb_tgt[r_idx]   <= jtgt;
                btb_ctr[r_idx]   <= CTR_ST;
            end else if (res_cb == CB_JR) begin
                btb_valid[r_idx] <= 1'b1;
                btb_tag[r_idx]   <= r_tag;
                btb_kind[r_idx]  <= KIND_RET;
                btb_ctr[r_idx]   <= CTR_ST;
            end
        end
    end

    br_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (active && res_cb == CB_JAL),
        .pop       (active && res_cb == CB_JR),
        .push_data (fall),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_br_predict_unit.sv
// Self-checking bench for br_predict_unit: vector table of resolves with a
// redirect scoreboard, plus hand sequences for training, RAS and reset.
module tb_br_predict_unit;
    import br_predict_unit_pkg::*;

    logic        clk, rst_n;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [3:0]  res_cb;
    logic [31:0] res_rs, res_rt;
    logic [15:0] res_offset;
    logic [25:0] res_index;
    logic        res_pred_taken;
    logic [31:0] res_pred_tgt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ra;

    br_predict_unit #(.BTB_ENTRIES(16), .RAS_DEPTH(4), .CTR_INIT(2'd1)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_cb(res_cb),
        .res_rs(res_rs), .res_rt(res_rt), .res_offset(res_offset),
        .res_index(res_index), .res_pred_taken(res_pred_taken),
        .res_pred_tgt(res_pred_tgt), .redirect(redirect),
        .redirect_pc(redirect_pc), .ra(ra)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  cb;
        logic [31:0] pc, rs, rt;
        logic [15:0] off;
        logic [25:0] idx;
        logic        ptk;
        logic [31:0] ptgt;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        string       name;
        logic        redir;
        logic [31:0] pc;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    localparam logic [31:0] JR_PC = 32'h0040_0208;

    function automatic vec_t mkv(input string name, input logic [3:0] cb,
                                 input logic [31:0] pc, rs, rt, input logic [15:0] off,
                                 input logic [25:0] idx, input logic ptk,
                                 input logic [31:0] ptgt, input logic er,
                                 input logic [31:0] epc);
        vec_t v;
        v.name = name; v.cb = cb; v.pc = pc; v.rs = rs; v.rt = rt; v.off = off;
        v.idx = idx; v.ptk = ptk; v.ptgt = ptgt; v.exp_redir = er; v.exp_pc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one resolve, expect redirect one edge later
    task automatic resolve(input vec_t v);
        sb_t e;
        @(negedge clk);
        res_valid = 1'b1; res_cb = v.cb; res_pc = v.pc; res_rs = v.rs; res_rt = v.rt;
        res_offset = v.off; res_index = v.idx; res_pred_taken = v.ptk; res_pred_tgt = v.ptgt;
        sb.push_back('{v.name, v.exp_redir, v.exp_pc});
        #1;
        if (v.cb == CB_JAL) chk({v.name, "_ra"}, ra, v.pc + 32'd8);
        @(posedge clk);
        #1;
        res_valid = 1'b0; res_cb = CB_NONE;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb.pop_front();
            chk({e.name, "_redir"}, {31'd0, redirect}, {31'd0, e.redir});
            chk({e.name, "_rpc"}, redirect_pc, e.pc);
        end
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic exp_tk, input logic [31:0] exp_tgt);
        @(negedge clk);
        fetch_pc = pc;
        #1;
        chk({name, "_ptk"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({name, "_ptgt"}, pred_target, exp_tgt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rets [5];
        rst_n = 1'b0; fetch_pc = 32'h0040_0000; res_valid = 1'b0; res_cb = CB_NONE;
        res_pc = '0; res_rs = '0; res_rt = '0; res_offset = '0; res_index = '0;
        res_pred_taken = 1'b0; res_pred_tgt = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_redir", {31'd0, redirect}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        lookup("rst_lookup", 32'h0040_0000, 1'b0, 32'h0040_0008);
        @(negedge clk); rst_n = 1'b1;

        // Resolve table
        vecs.push_back(mkv("beq_t1",   CB_BEQ,  32'h0040_0010, 32'd5, 32'd5, 16'h0004, 26'd0, 1'b0, 32'd0, 1'b1, 32'h0040_0024));
        vecs.push_back(mkv("beq_t2",   CB_BEQ,  32'h0040_0010, 32'd5, 32'd5, 16'h0004, 26'd0, 1'b0, 32'd0, 1'b1, 32'h0040_0024));
        vecs.push_back(mkv("bltz_neg", CB_BLTZ, 32'h0040_0040, 32'hFFFF_FFFF, 32'd0, 16'h0008, 26'd0, 1'b0, 32'd0, 1'b1, 32'h0040_0064));
        vecs.push_back(mkv("bgez_neg", CB_BGEZ, 32'h0040_0050, 32'hFFFF_FFFF, 32'd0, 16'h0008, 26'd0, 1'b0, 32'd0, 1'b0, 32'h0040_0058));
        vecs.push_back(mkv("bne_back", CB_BNE,  32'h0040_0060, 32'd1, 32'd2, 16'hFFFF, 26'd0, 1'b1, 32'h0040_0060, 1'b0, 32'h0040_0060));
        vecs.push_back(mkv("blez_tgt", CB_BLEZ, 32'h0040_0070, 32'd0, 32'd0, 16'h0002, 26'd0, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_007C));
        vecs.push_back(mkv("bgtz_zero",CB_BGTZ, 32'h0040_0080, 32'd0, 32'd0, 16'h0002, 26'd0, 1'b1, 32'h0040_008C, 1'b1, 32'h0040_0088));
        vecs.push_back(mkv("beq_alias",CB_BEQ,  32'h0040_0090, 32'd3, 32'd4, 16'h0004, 26'd0, 1'b0, 32'd0, 1'b0, 32'h0040_0098));
        vecs.push_back(mkv("j_hit",    CB_J,    32'h0040_00A0, 32'd0, 32'd0, 16'h0000, 26'h0100400, 1'b1, 32'h0040_1000, 1'b0, 32'h0040_1000));
        vecs.push_back(mkv("bgtz_max", CB_BGTZ, 32'h0040_00B0, 32'h7FFF_FFFF, 32'd0, 16'h0001, 26'd0, 1'b0, 32'd0, 1'b1, 32'h0040_00B8));
        for (int i = 0; i < vecs.size(); i++) resolve(vecs[i]);

        // Redirect is a single-cycle pulse
        @(posedge clk); #1;
        chk("redir_clear", {31'd0, redirect}, 32'd0);

        // Trained state after the table
        lookup("beq_st",    32'h0040_0010, 1'b1, 32'h0040_0024);
        lookup("j_uncond",  32'h0040_00A0, 1'b1, 32'h0040_1000);
        lookup("bgez_none", 32'h0040_0050, 1'b0, 32'h0040_0058);
        lookup("bltz_wt",   32'h0040_0040, 1'b1, 32'h0040_0064);
        lookup("bne_evict", 32'h0040_0060, 1'b0, 32'h0040_0068);

        // Counter walks down: 3 -> 2 still taken, 2 -> 1 not taken
        resolve(mkv("beq_nt1", CB_BEQ, 32'h0040_0010, 32'd1, 32'd2, 16'h0004, 26'd0, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_0018));
        lookup("beq_wt", 32'h0040_0010, 1'b1, 32'h0040_0024);
        resolve(mkv("beq_nt2", CB_BEQ, 32'h0040_0010, 32'd1, 32'd2, 16'h0004, 26'd0, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_0018));
        lookup("beq_wnt", 32'h0040_0010, 1'b0, 32'h0040_0018);

        // jal / jr through the RAS
        resolve(mkv("jal1", CB_JAL, 32'h0040_0100, 32'd0, 32'd0, 16'd0, 26'h0100040, 1'b0, 32'd0, 1'b1, 32'h0040_0100));
        resolve(mkv("jr_cold", CB_JR, JR_PC, 32'h0040_0108, 32'd0, 16'd0, 26'd0, 1'b0, 32'd0, 1'b1, 32'h0040_0108));
        lookup("jr_empty", JR_PC, 1'b0, JR_PC + 32'd8);
        resolve(mkv("jal2", CB_JAL, 32'h0040_0100, 32'd0, 32'd0, 16'd0, 26'h0100040, 1'b0, 32'd0, 1'b1, 32'h0040_0100));
        lookup("jr_ras", JR_PC, 1'b1, 32'h0040_0108);
        resolve(mkv("jr_hit", CB_JR, JR_PC, 32'h0040_0108, 32'd0, 16'd0, 26'd0, 1'b1, 32'h0040_0108, 1'b0, 32'h0040_0108));

        // RAS overflow: 5 pushes into 4 slots, then 5 pops
        for (int k = 0; k < 5; k++) begin
            logic [31:0] pc;
            pc = 32'h0040_0310 + 32'(4 * k);
            rets[k] = pc + 32'd8;
            resolve(mkv($sformatf("jal_ovf%0d", k), CB_JAL, pc, 32'd0, 32'd0, 16'd0,
                        26'h0100000 + 26'(k), 1'b0, 32'd0, 1'b1, 32'h0040_0000 + 32'(4 * k)));
        end
        for (int k = 0; k < 4; k++) begin
            lookup($sformatf("ras_top%0d", k), JR_PC, 1'b1, rets[4 - k]);
            resolve(mkv($sformatf("jr_pop%0d", k), CB_JR, JR_PC, rets[4 - k], 32'd0, 16'd0,
                        26'd0, 1'b1, rets[4 - k], 1'b0, rets[4 - k]));
        end
        lookup("ras_drained", JR_PC, 1'b0, JR_PC + 32'd8);
        resolve(mkv("jr_under", CB_JR, JR_PC, 32'h0040_0500, 32'd0, 16'd0, 26'd0, 1'b0, 32'd0, 1'b1, 32'h0040_0500));
        lookup("ras_still_empty", JR_PC, 1'b0, JR_PC + 32'd8);
        resolve(mkv("jal_after", CB_JAL, 32'h0040_0340, 32'd0, 32'd0, 16'd0, 26'h0100000, 1'b0, 32'd0, 1'b1, 32'h0040_0000));
        lookup("ras_one", JR_PC, 1'b1, 32'h0040_0348);

        // Reset right after a mispredict drops the pending redirect
        resolve(mkv("pre_rst", CB_BEQ, 32'h0040_0010, 32'd7, 32'd7, 16'h0004, 26'd0, 1'b0, 32'd0, 1'b1, 32'h0040_0024));
        rst_n = 1'b0;
        #1;
        chk("rst_drop_redir", {31'd0, redirect}, 32'd0);
        chk("rst_drop_rpc", redirect_pc, 32'd0);
        lookup("rst_beq_miss", 32'h0040_0010, 1'b0, 32'h0040_0018);
        lookup("rst_jr_miss", JR_PC, 1'b0, JR_PC + 32'd8);
        lookup("rst_j_miss", 32'h0040_00A0, 1'b0, 32'h0040_00A8);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_redir", {31'd0, redirect}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
